// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with sweep-level debounce; key_valid lands one cycle after the evaluating sweep boundary.
// No backpressure: key_valid/multi_key are single-cycle pulses with no handshake.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_key
);

  localparam int PW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {RELEASED, PRESSED} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} kind_t;

  logic [3:0]    row_meta, row_sync;
  logic          active;
  logic [1:0]    phase;
  logic [PW-1:0] ph_cnt;
  logic [15:0]   pressed;
  logic          eval;
  logic [SW-1:0] stab_cnt, stab_next;
  kind_t         prev_kind, res_kind;
  logic [3:0]    prev_code, res_code;
  logic [4:0]    n_keys;
  logic [3:0]    hit_idx;
  logic          same, stable, accept;
  state_t        state, state_nxt;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  // active holds the columns released for the cycle after reset, so phase 0 starts cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      phase   <= 2'd0;
      ph_cnt  <= '0;
      eval    <= 1'b0;
      pressed <= '0;
    end else begin
      active <= 1'b1;
      eval   <= 1'b0;
      if (active) begin
        if (ph_cnt == PH_LAST) begin
          ph_cnt                    <= '0;
          phase                     <= phase + 2'd1;
          pressed[{phase, 2'b00} +: 4] <= ~row_sync;
          eval                      <= (phase == 2'd3);
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign key_col[c] = (active && phase == 2'(c)) ? 1'b0 : 1'bz;
  end

  always_comb begin
    n_keys  = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        n_keys  = n_keys + 5'd1;
        hit_idx = 4'(i);
      end
    end
    res_kind = RES_MULTI;
    res_code = 4'h0;
    if (n_keys == 5'd0) begin
      res_kind = RES_NONE;
    end else if (n_keys == 5'd1) begin
      res_kind = RES_ONE;
      res_code = hit_idx;
    end
  end

  // A zero count means no previous sweep exists, so the first result always reloads to 1
  always_comb begin
    same      = (res_kind == prev_kind) && (res_code == prev_code) && (stab_cnt != '0);
    stab_next = SW'(1);
    if (same) begin
      stab_next = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + 1'b1;
    end
    stable = (stab_next == STAB_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt  <= '0;
      prev_kind <= RES_NONE;
      prev_code <= 4'h0;
    end else if (eval) begin
      stab_cnt  <= stab_next;
      prev_kind <= res_kind;
      prev_code <= res_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (eval && stable) begin
      case (state)
        RELEASED: if (res_kind == RES_ONE)  state_nxt = PRESSED;
        PRESSED:  if (res_kind == RES_NONE) state_nxt = RELEASED;
        default:  state_nxt = RELEASED;
      endcase
    end
  end

  always_comb begin
    accept    = eval && stable && (state == RELEASED) && (res_kind == RES_ONE);
    key_held  = (state == PRESSED);
    multi_key = eval && (res_kind == RES_MULTI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_code_q <= res_code;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a modelled 4x4 keypad answers the column drive, and a sweep-level
// reference model predicts presses, releases and multi-key pulses.
module tb_keypad_scanner;

  localparam int SETTLE = 16;
  localparam int DB     = 4;
  localparam int SWEEP  = 4 * SETTLE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  wire  [3:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        multi_key;
  logic [15:0] mask = '0;

  pullup (key_col[0]);
  pullup (key_col[1]);
  pullup (key_col[2]);
  pullup (key_col[3]);

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to a column that is being driven low
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (key_col[c] === 1'b0) begin
        for (int r = 0; r < 4; r++) begin
          if (mask[c*4 + r]) key_row[r] = 1'b0;
        end
      end
    end
  end

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  int vecs = 0;
  int errs = 0;
  int obs_vld = 0;
  int obs_multi = 0;

  // Reference model state, one step per completed sweep
  int          m_cnt = 0;
  int          m_prev_res = 0;
  bit          m_have_res = 0;
  logic        m_held = 1'b0;
  logic [3:0]  m_code = 4'h0;
  int          m_vld_exp = 0;
  int          m_multi_exp = 0;
  bit          have_prev = 0;
  logic [15:0] prev_mask = '0;

  // 0 = no key, 1..16 = single key code+1, 100 = two or more keys
  function automatic int classify(input logic [15:0] m);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        n++;
        idx = i;
      end
    end
    if (n == 0) return 0;
    if (n == 1) return idx + 1;
    return 100;
  endfunction

  task automatic model_step(input logic [15:0] m);
    int res;
    res = classify(m);
    if (res == 100) m_multi_exp++;
    if (m_have_res && res == m_prev_res) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
    else m_cnt = 1;
    m_prev_res = res;
    m_have_res = 1;
    if (m_cnt == DB) begin
      if (!m_held && res >= 1 && res <= 16) begin
        m_held = 1'b1;
        m_code = 4'(res - 1);
        m_vld_exp++;
      end else if (m_held && res == 0) begin
        m_held = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_cnt      = 0;
    m_prev_res = 0;
    m_have_res = 0;
    m_held     = 1'b0;
    m_code     = 4'h0;
    have_prev  = 0;
  endtask

  // One clock: sample outputs on the falling edge, then move just past the next rising edge
  task automatic run_cycle(input int t);
    logic [3:0] exp_col;
    @(negedge clk);
    if (t >= 0) begin
      exp_col = 4'b0001 << (t / SETTLE);
      exp_col = ~exp_col;
      vecs++;
      if (key_col !== exp_col) begin
        errs++;
        $display("FAIL col_phase t=%0d got %b want %b", t, key_col, exp_col);
      end
    end
    if (key_valid === 1'b1) begin
      obs_vld++;
      vecs++;
      if (key_code !== m_code) begin
        errs++;
        $display("FAIL code_at_valid got %h want %h", key_code, m_code);
      end
    end
    if (multi_key === 1'b1) obs_multi++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic [15:0] m);
    if (have_prev) model_step(prev_mask);
    mask = m;
    for (int t = 0; t < SWEEP; t++) run_cycle(t);
    prev_mask = m;
    have_prev = 1;
    vecs++;
    if (key_held !== m_held) begin
      errs++;
      $display("FAIL held_per_sweep got %b want %b", key_held, m_held);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs += 5;
    if (key_col !== 4'b1111) begin errs++; $display("FAIL rst_col got %b want 1111", key_col); end
    if (key_valid !== 1'b0)  begin errs++; $display("FAIL rst_valid got %b want 0", key_valid); end
    if (key_code !== 4'h0)   begin errs++; $display("FAIL rst_code got %h want 0", key_code); end
    if (key_held !== 1'b0)   begin errs++; $display("FAIL rst_held got %b want 0", key_held); end
    if (multi_key !== 1'b0)  begin errs++; $display("FAIL rst_multi got %b want 0", multi_key); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    mask = '0;
    do_reset();
  endtask

  task automatic test_col_trace();
    int v0;
    v0 = obs_vld;
    run_sweep(16'h0000);
    vecs++;
    if (obs_vld != v0) begin errs++; $display("FAIL trace_no_valid got %0d want 0", obs_vld - v0); end
  endtask

  task automatic test_press();
    int v0;
    v0 = obs_vld;
    for (int s = 0; s < 6; s++) run_sweep(16'h0200);
    vecs += 4;
    if (obs_vld - v0 != 1)    begin errs++; $display("FAIL press_valid_count got %0d want 1", obs_vld - v0); end
    if (obs_vld != m_vld_exp) begin errs++; $display("FAIL press_model_count got %0d want %0d", obs_vld, m_vld_exp); end
    if (key_code !== 4'h9)    begin errs++; $display("FAIL press_code got %h want 9", key_code); end
    if (key_held !== 1'b1)    begin errs++; $display("FAIL press_held got %b want 1", key_held); end
  endtask

  task automatic test_release();
    int v0;
    logic exp_held;
    v0 = obs_vld;
    for (int s = 0; s < 5; s++) begin
      run_sweep(16'h0000);
      exp_held = (s < 4);
      vecs++;
      if (key_held !== exp_held) begin
        errs++;
        $display("FAIL release_held sweep=%0d got %b want %b", s, key_held, exp_held);
      end
    end
    vecs += 2;
    if (obs_vld != v0)      begin errs++; $display("FAIL release_no_valid got %0d want 0", obs_vld - v0); end
    if (key_code !== 4'h9)  begin errs++; $display("FAIL release_code_kept got %h want 9", key_code); end
  endtask

  task automatic test_short();
    int v0;
    v0 = obs_vld;
    for (int s = 0; s < 2; s++) run_sweep(16'h0200);
    for (int s = 0; s < 4; s++) run_sweep(16'h0000);
    vecs += 2;
    if (obs_vld != v0)     begin errs++; $display("FAIL short_no_valid got %0d want 0", obs_vld - v0); end
    if (key_held !== 1'b0) begin errs++; $display("FAIL short_held got %b want 0", key_held); end
  endtask

  task automatic test_multi();
    int v0, mu0;
    v0  = obs_vld;
    mu0 = obs_multi;
    for (int s = 0; s < 5; s++) run_sweep(16'h1010);
    run_sweep(16'h0000);
    vecs += 3;
    if (obs_multi - mu0 != 5)     begin errs++; $display("FAIL multi_count got %0d want 5", obs_multi - mu0); end
    if (obs_multi != m_multi_exp) begin errs++; $display("FAIL multi_model got %0d want %0d", obs_multi, m_multi_exp); end
    if (obs_vld != v0)            begin errs++; $display("FAIL multi_no_valid got %0d want 0", obs_vld - v0); end
    for (int s = 0; s < 4; s++) run_sweep(16'h0000);
  endtask

  task automatic test_random();
    int kind, len, a, b;
    logic [15:0] m;
    for (int seg = 0; seg < 16; seg++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 6);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      m    = '0;
      if (kind == 1 || kind == 2) m[a] = 1'b1;
      if (kind == 3) begin
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
      for (int s = 0; s < len; s++) run_sweep(m);
      vecs += 3;
      if (obs_vld != m_vld_exp)     begin errs++; $display("FAIL rand_valid seg=%0d got %0d want %0d", seg, obs_vld, m_vld_exp); end
      if (obs_multi != m_multi_exp) begin errs++; $display("FAIL rand_multi seg=%0d got %0d want %0d", seg, obs_multi, m_multi_exp); end
      if (key_code !== m_code)      begin errs++; $display("FAIL rand_code seg=%0d got %h want %h", seg, key_code, m_code); end
    end
  endtask

  task automatic test_reset_pressed();
    int k, lat, pulses;
    logic held_at;
    logic [15:0] m;
    bit found;
    k = $urandom_range(0, 15);
    m = '0;
    m[k] = 1'b1;
    for (int s = 0; s < 6; s++) run_sweep(m);
    vecs += 2;
    if (key_held !== 1'b1)  begin errs++; $display("FAIL rp_held_before got %b want 1", key_held); end
    if (key_code !== 4'(k)) begin errs++; $display("FAIL rp_code_before got %h want %h", key_code, 4'(k)); end
    for (int t = 0; t < 23; t++) run_cycle(t);
    do_reset();
    found   = 0;
    lat     = -1;
    pulses  = 0;
    held_at = 1'b0;
    for (int c = 0; c < 5 * SWEEP; c++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        pulses++;
        if (!found) begin
          found   = 1;
          lat     = c;
          held_at = key_held;
        end
      end
      @(posedge clk);
      #1;
    end
    vecs += 5;
    if (!found)             begin errs++; $display("FAIL rp_timeout got no key_valid within %0d cycles want one", 5 * SWEEP); end
    if (lat != 257)         begin errs++; $display("FAIL rp_latency got %0d want 257", lat); end
    if (pulses != 1)        begin errs++; $display("FAIL rp_pulses got %0d want 1", pulses); end
    if (held_at !== 1'b1)   begin errs++; $display("FAIL rp_held_at_valid got %b want 1", held_at); end
    if (key_code !== 4'(k)) begin errs++; $display("FAIL rp_code got %h want %h", key_code, 4'(k)); end
  endtask

  initial begin
    test_reset();
    test_col_trace();
    test_press();
    test_release();
    test_short();
    test_multi();
    test_random();
    test_reset_pressed();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
